if_tracker: RTL and testbench
=============================

// Module: if_tracker
// PURPOSE
//  Passive monitor of the core's instruction-fetch memory port, inside trace_unit.
//  Timestamps each fetch at request start, grant and rvalid using the parent's cycle counter.
//  Emits one trace_output record per completed fetch with a one-cycle if_data_ready strobe.
//  Never drives the memory bus; purely observational.
// PARAMETERS
//  ADDR_WIDTH   32  instruction address width
//  DATA_WIDTH   32  instruction data width
//  PEND_DEPTH    4  max granted-but-not-returned fetches tracked (power of 2)
// PORTS
//  clk            in   1    clock, all state on rising edge
//  rst            in   1    asynchronous, active-low reset
//  counter        in   32   parent cycle count (integer), sampled as timestamp
//  if_busy        in   1    IF stage busy
//  if_ready       in   1    IF stage ready
//  instr_req      in   1    fetch request
//  instr_addr     in   ADDR_WIDTH  fetch address, valid with instr_req
//  instr_grant    in   1    request accepted this cycle when instr_req=1
//  instr_rvalid   in   1    read data returned this cycle
//  instr_rdata    in   DATA_WIDTH  returned instruction
//  if_data_ready  out  1    one-cycle strobe: if_data_o holds a new record
//  if_data_o      out  trace_output  record {addr, data, req_time, gnt_time, rvalid_time, busy_at_gnt, overflow}
// BEHAVIOUR
//  - Reset (rst=0, async): if_data_ready=0, if_data_o all-zero, queue empty,
//    req_open=0, overflow=0. Reset mid-fetch discards all pending entries.
//  - Request start: first cycle instr_req=1 with req_open=0 latches req_start=counter;
//    req_open=1 until the grant cycle. Same-cycle req+grant: req_time=gnt_time=counter.
//  - Grant (instr_req & instr_grant): push {instr_addr, req_start, counter, if_busy}
//    into PEND_DEPTH FIFO; clear req_open. Back-to-back grants each push one entry;
//    req_open re-arms next cycle if instr_req stays high.
//  - Address change while req_open without grant: req_start not reset (abort not modelled).
//  - Return (instr_rvalid, queue non-empty): pop head; next cycle if_data_o =
//    {head.addr, instr_rdata, head.req_time, head.gnt_time, counter at rvalid,
//    head.busy_at_gnt, overflow}; if_data_ready=1 for exactly that cycle.
//  - Latency: rvalid in cycle N -> if_data_ready in cycle N+1. Records in grant order.
//  - if_data_o holds last record until the next one; if_data_ready otherwise 0.
//  - Grant and rvalid same cycle: pop precedes push; rvalid applies to an older grant.
//  - rvalid with queue empty (incl. same-cycle grant into empty queue): ignored, no record.
//  - Grant with queue full and no pop: entry dropped, sticky overflow=1 (cleared only
//    by reset), reported in all later records.
//  - Timestamps are raw 32-bit counter copies; wrap is modular, no correction.
//  - if_ready is monitored only; it does not affect records in this revision.
//  - FIFO pointers wrap modulo PEND_DEPTH; count 0..PEND_DEPTH.
// TESTING
//  1. Reset low mid-fetch -> ready=0, data_o=0; after release, first rvalid ignored.
//  2. req@counter=5, grant@7, rvalid(rdata=0x00000013)@9, addr=0x80 -> ready @counter 10,
//     record {0x80, 0x13, 5, 7, 9, busy_at_gnt, ovf=0}.
//  3. Grants at 0x100,0x104,0x108 back-to-back, rvalids later -> three records in order,
//     req_time==gnt_time each.
//  4. Grant and rvalid same cycle with 1 pending -> old entry out, new entry queued.
//  5. Five grants with no rvalid (PEND_DEPTH=4) -> fifth dropped; later records ovf=1.
//  6. rvalid with empty queue -> if_data_ready stays 0, if_data_o unchanged.

Source files
------------

// File: rtl/if_tracker.sv
// Passive instruction-fetch monitor: timestamps req/grant/rvalid and emits one record per completed fetch.
// Latency: rvalid in cycle N -> if_data_ready in N+1. No backpressure; grants into a full queue are dropped and flagged.
module if_tracker #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int PEND_DEPTH = 4,
    localparam int REC_W     = ADDR_WIDTH + DATA_WIDTH + 3 * 32 + 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           counter,
    input  logic                  if_busy,
    input  logic                  if_ready,
    input  logic                  instr_req,
    input  logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic                  instr_grant,
    input  logic                  instr_rvalid,
    input  logic [DATA_WIDTH-1:0] instr_rdata,
    output logic                  if_data_ready,
    output logic [REC_W-1:0]      if_data_o
);

    localparam int PTR_W = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
    localparam int CNT_W = $clog2(PEND_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [31:0]           req_time;
        logic [31:0]           gnt_time;
        logic [31:0]           rvalid_time;
        logic                  busy_at_gnt;
        logic                  overflow;
    } trace_output_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           req_time;
        logic [31:0]           gnt_time;
        logic                  busy_at_gnt;
    } pend_t;

    logic              req_open;
    logic [31:0]       req_start;
    pend_t             mem [PEND_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    trace_output_t     rec_q;
    logic              rdy_q;

    logic              grant;
    logic              pop;
    logic              full;
    logic              push;
    logic              drop;
    pend_t             new_entry;
    pend_t             head;

    // if_ready is observed only; it has no effect on records yet.
    logic unused_if_ready;
    assign unused_if_ready = if_ready;

    always_comb begin
        grant = instr_req & instr_grant;
        pop   = instr_rvalid & (count != '0);
        full  = (count == CNT_W'(PEND_DEPTH));
        // A pop in the same cycle frees the slot the push needs.
        push  = grant & (~full | pop);
        drop  = grant & full & ~pop;
        head  = mem[rd_ptr];
        new_entry = '{addr:        instr_addr,
                      req_time:    req_open ? req_start : counter,
                      gnt_time:    counter,
                      busy_at_gnt: if_busy};
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_open  <= 1'b0;
            req_start <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            rdy_q     <= 1'b0;
            rec_q     <= '0;
        end else begin
            if (grant) begin
                req_open <= 1'b0;
            end else if (instr_req && !req_open) begin
                req_open  <= 1'b1;
                req_start <= counter;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            if (drop) begin
                overflow <= 1'b1;
            end

            rdy_q <= pop;
            if (pop) begin
                rec_q <= '{addr:        head.addr,
                           data:        instr_rdata,
                           req_time:    head.req_time,
                           gnt_time:    head.gnt_time,
                           rvalid_time: counter,
                           busy_at_gnt: head.busy_at_gnt,
                           overflow:    overflow};
            end
        end
    end

    assign if_data_ready = rdy_q;
    assign if_data_o     = rec_q;

endmodule

// File: tb/tb_if_tracker.sv
// Directed bench for if_tracker: reset, single fetch, pipelined grants, grant/rvalid overlap, overflow, stray rvalid.
module tb_if_tracker;

    localparam int REC_W = 32 + 32 + 3 * 32 + 2;

    logic             clk;
    logic             rst;
    logic [31:0]      counter;
    logic             if_busy;
    logic             if_ready;
    logic             instr_req;
    logic [31:0]      instr_addr;
    logic             instr_grant;
    logic             instr_rvalid;
    logic [31:0]      instr_rdata;
    logic             if_data_ready;
    logic [REC_W-1:0] if_data_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] o_addr, o_data, o_req, o_gnt, o_rv;
    logic        o_busy, o_ovf;
    assign o_addr = if_data_o[161:130];
    assign o_data = if_data_o[129:98];
    assign o_req  = if_data_o[97:66];
    assign o_gnt  = if_data_o[65:34];
    assign o_rv   = if_data_o[33:2];
    assign o_busy = if_data_o[1];
    assign o_ovf  = if_data_o[0];

    if_tracker #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PEND_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .counter       (counter),
        .if_busy       (if_busy),
        .if_ready      (if_ready),
        .instr_req     (instr_req),
        .instr_addr    (instr_addr),
        .instr_grant   (instr_grant),
        .instr_rvalid  (instr_rvalid),
        .instr_rdata   (instr_rdata),
        .if_data_ready (if_data_ready),
        .if_data_o     (if_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_rec(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] rq, input logic [31:0] gn, input logic [31:0] rv,
                             input logic b, input logic o);
        chk({tag, "_rdy"},  64'(if_data_ready), 64'd1);
        chk({tag, "_addr"}, 64'(o_addr), 64'(a));
        chk({tag, "_data"}, 64'(o_data), 64'(d));
        chk({tag, "_req"},  64'(o_req),  64'(rq));
        chk({tag, "_gnt"},  64'(o_gnt),  64'(gn));
        chk({tag, "_rv"},   64'(o_rv),   64'(rv));
        chk({tag, "_busy"}, 64'(o_busy), 64'(b));
        chk({tag, "_ovf"},  64'(o_ovf),  64'(o));
    endtask

    // Inputs change 1 time unit after the rising edge; counter advances once per cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        counter = counter + 32'd1;
    endtask

    logic [31:0] t0, g1, g2, g3, r;
    logic [31:0] gt [5];

    initial begin
        rst = 1'b0; counter = '0; if_busy = 1'b0; if_ready = 1'b1;
        instr_req = 1'b0; instr_addr = '0; instr_grant = 1'b0;
        instr_rvalid = 1'b0; instr_rdata = '0;
        tick(); tick();
        chk("rst_rdy", 64'(if_data_ready), 64'd0);
        chk("rst_data_zero", 64'(if_data_o == '0), 64'd1);

        // Build a record, queue another fetch, then reset mid-fetch.
        rst = 1'b1; tick();
        instr_req = 1'b1; instr_grant = 1'b1; instr_addr = 32'h40; tick();
        instr_req = 1'b0; instr_grant = 1'b0; instr_rvalid = 1'b1; instr_rdata = 32'h11; tick();
        instr_rvalid = 1'b0;
        chk("pre_rst_rdy", 64'(if_data_ready), 64'd1);
        chk("pre_rst_addr", 64'(o_addr), 64'h40);
        instr_req = 1'b1; instr_grant = 1'b1; instr_addr = 32'h44; tick();
        instr_req = 1'b0; instr_grant = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("midrst_rdy", 64'(if_data_ready), 64'd0);
        chk("midrst_data_zero", 64'(if_data_o == '0), 64'd1);
        #1 rst = 1'b1;
        instr_rvalid = 1'b1; instr_rdata = 32'h55; tick();
        instr_rvalid = 1'b0;
        chk("postrst_ign_rdy", 64'(if_data_ready), 64'd0);
        chk("postrst_ign_data", 64'(if_data_o == '0), 64'd1);

        // Single fetch: req@5 (address moves while open), grant@7, rvalid@9.
        counter = 32'd5;
        instr_req = 1'b1; instr_addr = 32'h7C; tick();
        instr_addr = 32'h80; tick();
        instr_grant = 1'b1; if_busy = 1'b1; tick();
        instr_req = 1'b0; instr_grant = 1'b0; if_busy = 1'b0; tick();
        instr_rvalid = 1'b1; instr_rdata = 32'h13; tick();
        instr_rvalid = 1'b0;
        chk("t2_counter_at_rdy", 64'(counter), 64'd10);
        check_rec("t2", 32'h80, 32'h13, 32'd5, 32'd7, 32'd9, 1'b1, 1'b0);
        tick();
        chk("t2_strobe_low", 64'(if_data_ready), 64'd0);
        chk("t2_hold_addr", 64'(o_addr), 64'h80);

        // Back-to-back grants, then back-to-back returns.
        t0 = counter;
        instr_req = 1'b1; instr_grant = 1'b1; instr_addr = 32'h100; tick();
        instr_addr = 32'h104; tick();
        instr_addr = 32'h108; tick();
        instr_req = 1'b0; instr_grant = 1'b0; tick();
        r = counter;
        instr_rvalid = 1'b1; instr_rdata = 32'hA0; tick();
        check_rec("t3_0", 32'h100, 32'hA0, t0, t0, r, 1'b0, 1'b0);
        instr_rdata = 32'hA1; tick();
        check_rec("t3_1", 32'h104, 32'hA1, t0 + 1, t0 + 1, r + 1, 1'b0, 1'b0);
        instr_rdata = 32'hA2; tick();
        instr_rvalid = 1'b0;
        check_rec("t3_2", 32'h108, 32'hA2, t0 + 2, t0 + 2, r + 2, 1'b0, 1'b0);

        // Grant and rvalid together with one entry pending.
        g1 = counter;
        instr_req = 1'b1; instr_grant = 1'b1; instr_addr = 32'h200; tick();
        instr_req = 1'b0; instr_grant = 1'b0; tick();
        g2 = counter;
        instr_req = 1'b1; instr_grant = 1'b1; instr_addr = 32'h204;
        instr_rvalid = 1'b1; instr_rdata = 32'hAA; tick();
        instr_req = 1'b0; instr_grant = 1'b0; instr_rvalid = 1'b0;
        check_rec("t4_old", 32'h200, 32'hAA, g1, g1, g2, 1'b0, 1'b0);
        tick();
        r = counter;
        instr_rvalid = 1'b1; instr_rdata = 32'hBB; tick();
        instr_rvalid = 1'b0;
        check_rec("t4_new", 32'h204, 32'hBB, g2, g2, r, 1'b0, 1'b0);

        // rvalid alongside a grant into an empty queue is ignored; the grant is kept.
        g3 = counter;
        instr_req = 1'b1; instr_grant = 1'b1; instr_addr = 32'h300;
        instr_rvalid = 1'b1; instr_rdata = 32'hCC; tick();
        instr_req = 1'b0; instr_grant = 1'b0;
        chk("t6_same_rdy", 64'(if_data_ready), 64'd0);
        chk("t6_same_hold", 64'(o_data), 64'hBB);
        r = counter;
        instr_rdata = 32'hDD; tick();
        check_rec("t6_q", 32'h300, 32'hDD, g3, g3, r, 1'b0, 1'b0);
        instr_rdata = 32'hEE; tick();
        instr_rvalid = 1'b0;
        chk("t6_empty_rdy", 64'(if_data_ready), 64'd0);
        chk("t6_empty_hold", 64'(o_data), 64'hDD);

        // Five grants into a depth-4 queue: the fifth is dropped and overflow sticks.
        for (int k = 0; k < 5; k++) begin
            gt[k] = counter;
            instr_req = 1'b1; instr_grant = 1'b1;
            instr_addr = 32'h400 + 32'(4 * k); if_busy = (k % 2 == 1);
            tick();
        end
        instr_req = 1'b0; instr_grant = 1'b0; if_busy = 1'b0; tick();
        for (int k = 0; k < 4; k++) begin
            r = counter;
            instr_rvalid = 1'b1; instr_rdata = 32'h500 + 32'(k); tick();
            check_rec($sformatf("t5_%0d", k), 32'h400 + 32'(4 * k), 32'h500 + 32'(k),
                      gt[k], gt[k], r, (k % 2 == 1), 1'b1);
        end
        instr_rdata = 32'h5FF; tick();
        instr_rvalid = 1'b0;
        chk("t5_fifth_dropped", 64'(if_data_ready), 64'd0);
        chk("t5_hold", 64'(o_data), 64'h503);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
